// File: rtl/button_conditioner_if.sv
// Push-button conditioner bus: raw button inputs plus debounced levels and
// one-cycle increment/decrement requests for the duty-cycle stage.
interface button_conditioner_if;
    logic button_up;
    logic button_down;
    logic up_level;
    logic down_level;
    logic up_pulse;
    logic down_pulse;

    // Side that drives the buttons and consumes the conditioned outputs
    modport master (
        output button_up,
        output button_down,
        input  up_level,
        input  down_level,
        input  up_pulse,
        input  down_pulse
    );

    // Conditioner side
    modport slave (
        input  button_up,
        input  button_down,
        output up_level,
        output down_level,
        output up_pulse,
        output down_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Two-button conditioner: 2-flop synchronizer, 24-bit debounce and a
// press/auto-repeat pulse generator per button, with up/down conflict masking.
// Optional feature macro: BTN_AUTOREPEAT_EN enables the DELAY/REPEAT
// auto-repeat states and timer; without it each press emits exactly one pulse.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 1200000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    button_conditioner_if.slave        bus
);
    localparam int unsigned     CNT_W   = 24;
    localparam int unsigned     N_BTN   = 2;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject configurations outside the legal counter range at elaboration
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 24'hFF_FFFF ||
        REPEAT_DELAY < 2 || REPEAT_DELAY > 24'hFF_FFFF ||
        REPEAT_PERIOD < 2 || REPEAT_PERIOD > 24'hFF_FFFF) begin : g_bad_cfg
        $error("button_conditioner: parameter out of range 2..2^24-1");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;
`endif

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] level_c;
    logic [N_BTN-1:0] emit_c;
    logic             conflict_c;
    logic             rst_ok_q;

    logic up_level_q;
    logic down_level_q;
    logic up_pulse_q;
    logic down_pulse_q;

    assign btn_raw = {bus.button_down, bus.button_up};

    // Reset release: state is held cleared until the edge after this flop sets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_ok_q <= 1'b0;
        end else begin
            rst_ok_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             level_prev_q;
        logic             rise_c;

        // Debounce next state: count while input disagrees, flip on the last count
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            if (sync2_q != level_q) begin
                if (cnt_q == DB_LAST) begin
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Synchronizer, debounce counter and edge-detect history
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                cnt_q        <= '0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
            end else if (!rst_ok_q) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                cnt_q        <= '0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
            end else begin
                sync1_q      <= btn_raw[i];
                sync2_q      <= sync1_q;
                cnt_q        <= cnt_d;
                level_q      <= level_d;
                level_prev_q <= level_q;
            end
        end

        assign rise_c     = level_q & ~level_prev_q;
        assign level_c[i] = level_q;

`ifdef BTN_AUTOREPEAT_EN
        state_e           state_q;
        logic [CNT_W-1:0] timer_q;
        logic             fall_c;
        logic             delay_hit_c;
        logic             period_hit_c;

        assign fall_c       = ~level_q & level_prev_q;
        assign delay_hit_c  = (state_q == ST_DELAY)  && (timer_q == RD_LAST);
        assign period_hit_c = (state_q == ST_REPEAT) && (timer_q == RP_LAST);
        // Release always wins over a timer expiry landing on the same cycle
        assign emit_c[i]    = ((state_q == ST_IDLE) && rise_c) ||
                              (!fall_c && (delay_hit_c || period_hit_c));

        // Press / initial-delay / auto-repeat sequencer
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
            end else if (!rst_ok_q || fall_c) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise_c) begin
                            state_q <= ST_DELAY;
                            timer_q <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (timer_q == RD_LAST) begin
                            state_q <= ST_REPEAT;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (timer_q == RP_LAST) begin
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        timer_q <= '0;
                    end
                endcase
            end
        end
`else
        // Single pulse per debounced press
        assign emit_c[i] = rise_c;
`endif
    end

    assign conflict_c = level_c[0] & level_c[1];

    // Registered outputs; pulses are dropped (not queued) while both buttons are held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_level_q   <= 1'b0;
            down_level_q <= 1'b0;
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
        end else if (!rst_ok_q) begin
            up_level_q   <= 1'b0;
            down_level_q <= 1'b0;
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
        end else begin
            up_level_q   <= level_c[0];
            down_level_q <= level_c[1];
            up_pulse_q   <= emit_c[0] & ~conflict_c;
            down_pulse_q <= emit_c[1] & ~conflict_c;
        end
    end

    assign bus.up_level   = up_level_q;
    assign bus.down_level = down_level_q;
    assign bus.up_pulse   = up_pulse_q;
    assign bus.down_pulse = down_pulse_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=5).
// Cycle numbering: cyc counts rising edges; an input driven at the falling
// edge seen with cyc=c is first sampled by edge T=c+1.
module tb_button_conditioner;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_up[$];
    int   exp_dn[$];
    int   seen_up = 0;
    int   seen_dn = 0;

    button_conditioner_if bus();

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pops the oldest expected pulse cycle for the channel and compares
    task automatic mon_pulse(input int ch);
        int exp_cyc;
        exp_cyc = -1;
        if (ch == 0) begin
            seen_up++;
            if (exp_up.size() != 0) exp_cyc = exp_up.pop_front();
            check("up_pulse_cycle", cyc, exp_cyc);
        end else begin
            seen_dn++;
            if (exp_dn.size() != 0) exp_cyc = exp_dn.pop_front();
            check("down_pulse_cycle", cyc, exp_cyc);
        end
    endtask

    // Monitor: samples outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus.up_pulse === 1'b1)   mon_pulse(0);
        if (bus.down_pulse === 1'b1) mon_pulse(1);
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic end_scenario(input string name, input int n_up, input int n_dn);
        check({name, "_up_count"}, seen_up, n_up);
        check({name, "_down_count"}, seen_dn, n_dn);
        check({name, "_up_missing"}, exp_up.size(), 0);
        check({name, "_down_missing"}, exp_dn.size(), 0);
        exp_up.delete();
        exp_dn.delete();
        seen_up = 0;
        seen_dn = 0;
    endtask

    initial begin
        int t;
        int p;
        int r;
        int n;
        bus.button_up   = 1'b0;
        bus.button_down = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_up_level",   int'(bus.up_level),   0);
        check("rst_down_level", int'(bus.down_level), 0);
        check("rst_up_pulse",   int'(bus.up_pulse),   0);
        check("rst_down_pulse", int'(bus.down_pulse), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Bouncing up button (2-cycle toggles) then a clean hold
        for (int k = 0; k < 10; k++) begin
            bus.button_up = ((k % 2) == 0);
            repeat (2) @(negedge clk);
        end
        t = cyc + 1;
        bus.button_up = 1'b1;
        exp_up.push_back(t + 6);
        wait_until(t + 5);
        check("bounce_level_before", int'(bus.up_level), 0);
        wait_until(t + 6);
        check("bounce_level_rise", int'(bus.up_level), 1);
        wait_until(t + 7);
        bus.button_up = 1'b0;
        wait_until(t + 25);
        end_scenario("bounce", 1, 0);

        // Long hold: press pulse, then auto-repeat until the release lands
        t = cyc + 1;
        bus.button_up = 1'b1;
        exp_up.push_back(t + 6);
`ifdef BTN_AUTOREPEAT_EN
        exp_up.push_back(t + 16);
        exp_up.push_back(t + 21);
        exp_up.push_back(t + 26);
        exp_up.push_back(t + 31);
        exp_up.push_back(t + 36);
        n = 6;
`else
        n = 1;
`endif
        wait_until(t + 34);
        bus.button_up = 1'b0;
        wait_until(t + 40);
        check("hold_level_high", int'(bus.up_level), 1);
        wait_until(t + 41);
        check("hold_level_fall", int'(bus.up_level), 0);
        wait_until(t + 55);
        end_scenario("hold", n, 0);

        // Down press released before the repeat delay expires
        t = cyc + 1;
        p = t + 6;
        bus.button_down = 1'b1;
        exp_dn.push_back(p);
        wait_until(p + 2);
        bus.button_down = 1'b0;
        wait_until(p + 8);
        check("down_level_held", int'(bus.down_level), 1);
        wait_until(p + 9);
        check("down_level_fall", int'(bus.down_level), 0);
        wait_until(p + 25);
        end_scenario("down_release", 0, 1);

        // Both buttons together: levels follow, every pulse suppressed
        t = cyc + 1;
        bus.button_up   = 1'b1;
        bus.button_down = 1'b1;
        wait_until(t + 6);
        check("both_up_level",   int'(bus.up_level),   1);
        check("both_down_level", int'(bus.down_level), 1);
        wait_until(t + 29);
        bus.button_up   = 1'b0;
        bus.button_down = 1'b0;
        wait_until(t + 45);
        end_scenario("both", 0, 0);

        // Reset while held in the repeat phase, button kept down across reset
        t = cyc + 1;
        bus.button_up = 1'b1;
        exp_up.push_back(t + 6);
`ifdef BTN_AUTOREPEAT_EN
        exp_up.push_back(t + 16);
        n = 3;
`else
        n = 2;
`endif
        wait_until(t + 18);
        rst_n = 1'b0;
        #1;
        check("async_rst_up_level", int'(bus.up_level), 0);
        check("async_rst_up_pulse", int'(bus.up_pulse), 0);
        repeat (3) @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        exp_up.push_back(r + 8);
        wait_until(r + 7);
        check("post_rst_level_low", int'(bus.up_level), 0);
        wait_until(r + 8);
        check("post_rst_level_high", int'(bus.up_level), 1);
        wait_until(r + 9);
        bus.button_up = 1'b0;
        wait_until(r + 30);
        end_scenario("reset_hold", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
